// File: rtl/alu_pipe_gated.sv
// Two-stage pipelined ALU with valid/ready handshakes, per-result flags and a saturating
// completion counter. Define ALU_CLK_GATE_EN to clock each datapath stage from a latch-based gate.
module alu_pipe_gated #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             r_s1_valid;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_negative;
  logic             r_overflow;
  logic [CNT_W-1:0] r_op_count;

  logic             w_s1_load;
  logic             w_s2_load;
  logic             w_in_ready;
  logic             w_xfer;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  logic             w_clk_s1;
  logic             w_clk_s2;
  logic             w_ld_s1;
  logic             w_ld_s2;

  assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready);
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_s1_load  = in_valid && w_in_ready;
  assign w_xfer     = r_out_valid && out_ready;

`ifdef ALU_CLK_GATE_EN
  logic r_en_s1_lat;
  logic r_en_s2_lat;

  // Stage enables are captured while clk is low so the gated clocks cannot glitch.
  always_latch begin
    if (!clk) begin
      r_en_s1_lat <= w_s1_load;
      r_en_s2_lat <= w_s2_load;
    end
  end

  assign w_clk_s1 = clk & r_en_s1_lat;
  assign w_clk_s2 = clk & r_en_s2_lat;
  assign w_ld_s1  = 1'b1;
  assign w_ld_s2  = 1'b1;
`else
  assign w_clk_s1 = clk;
  assign w_clk_s2 = clk;
  assign w_ld_s1  = w_s1_load;
  assign w_ld_s2  = w_s2_load;
`endif

  // Pipeline occupancy: a stage fills on load and empties when drained with no replacement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Completed-transfer counter, pinned at its maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_count <= {CNT_W{1'b0}};
    end else if (w_xfer && (r_op_count != CNT_MAX)) begin
      r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Stage 1 operand capture.
  always_ff @(posedge w_clk_s1 or posedge reset) begin
    if (reset) begin
      r_a  <= {WIDTH{1'b0}};
      r_b  <= {WIDTH{1'b0}};
      r_op <= 3'b000;
    end else if (w_ld_s1) begin
      r_a  <= a;
      r_b  <= b;
      r_op <= opcode;
    end
  end

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  // Stage 2 arithmetic; the top bit of w_diff is the unsigned borrow (A < B).
  always_comb begin
    w_res   = {WIDTH{1'b0}};
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_SHL: begin
        w_res   = {r_a[WIDTH-2:0], 1'b0};
        w_carry = r_a[WIDTH-1];
      end
      OP_SHR: begin
        w_res   = {1'b0, r_a[WIDTH-1:1]};
        w_carry = r_a[0];
      end
      OP_CMP: begin
        w_res   = {{(WIDTH-1){1'b0}}, (r_a == r_b)};
        w_carry = w_diff[WIDTH];
      end
      default: begin
        w_res   = {WIDTH{1'b0}};
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
    endcase
  end

  // Stage 2 result and flag registers.
  always_ff @(posedge w_clk_s2 or posedge reset) begin
    if (reset) begin
      r_result   <= {WIDTH{1'b0}};
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_ld_s2) begin
      r_result   <= w_res;
      r_carry    <= w_carry;
      r_zero     <= (w_res == {WIDTH{1'b0}});
      r_negative <= w_res[WIDTH-1];
      r_overflow <= w_ovf;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign overflow  = r_overflow;
  assign op_count  = r_op_count;

endmodule
